// File: rtl/controle_somador.sv
// Serial W-bit adder that reuses a single 4-bit nibble adder, one nibble per clock, LSB nibble first.
// Optional feature: define CARRY_OUT_EN to expose the final carry on port carry_out.
module controle_somador #(
  parameter int N_NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic [4*N_NIBBLES-1:0] a,
  input  logic [4*N_NIBBLES-1:0] b,
  output logic [4*N_NIBBLES-1:0] soma,
  output logic                   ocupado,
`ifdef CARRY_OUT_EN
  output logic                   carry_out,
`endif
  output logic                   pronto
);

  localparam int W    = 4 * N_NIBBLES;
  localparam int IDXW = $clog2(N_NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NIBBLES - 1);

  typedef enum logic [1:0] {OCIOSO, CALC, FIM} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_soma;
  logic            r_carry;
  logic [IDXW-1:0] r_idx;
  logic            r_ocupado;
  logic            r_pronto;
`ifdef CARRY_OUT_EN
  logic            r_carryOut;
`endif

  logic [3:0]      w_aNib;
  logic [3:0]      w_bNib;
  logic [4:0]      w_sum;
  logic [W-1:0]    w_accNext;

  // The accumulator with the current nibble already merged in, so the final
  // nibble can be published to soma on the same edge it is computed.
  always_comb begin
    w_aNib    = r_a[{r_idx, 2'b00} +: 4];
    w_bNib    = r_b[{r_idx, 2'b00} +: 4];
    w_sum     = {1'b0, w_aNib} + {1'b0, w_bNib} + {4'd0, r_carry};
    w_accNext = r_acc;
    w_accNext[{r_idx, 2'b00} +: 4] = w_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= OCIOSO;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_soma    <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
`ifdef CARRY_OUT_EN
      r_carryOut <= 1'b0;
`endif
    end else begin
      case (r_state)
        OCIOSO: begin
          r_pronto <= 1'b0;
          if (inicio) begin
            r_state   <= CALC;
            r_a       <= a;
            r_b       <= b;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            r_ocupado <= 1'b1;
          end
        end
        CALC: begin
          r_acc   <= w_accNext;
          r_carry <= w_sum[4];
          if (r_idx == LAST_IDX) begin
            r_state  <= FIM;
            r_soma   <= w_accNext;
            r_pronto <= 1'b1;
`ifdef CARRY_OUT_EN
            r_carryOut <= w_sum[4];
`endif
          end else begin
            r_idx <= r_idx + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        FIM: begin
          r_state   <= OCIOSO;
          r_pronto  <= 1'b0;
          r_ocupado <= 1'b0;
        end
        default: begin
          r_state   <= OCIOSO;
          r_pronto  <= 1'b0;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign soma    = r_soma;
  assign ocupado = r_ocupado;
  assign pronto  = r_pronto;
`ifdef CARRY_OUT_EN
  assign carry_out = r_carryOut;
`endif

endmodule
